sprite_animator: RTL and testbench

//  Parametrised successor to the single-pose sprite controller. Renders one WxH sprite from an

---
 rtl/sprite_pkg.sv | 28 ++
 rtl/sprite_anim_seq.sv | 88 ++++++++
 rtl/sprite_animator.sv | 159 +++++++++++++++
 tb/tb_sprite_animator.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite animator block.
//   COLOR_W        : RGB colour width (4:4:4)
//   CNT_W          : width of the VGA hCount/vCount counters
//   IDX_W          : width of the animation frame index
//   TRANSP_DEFAULT : default colour key treated as transparent
//   anim_state_e   : frame sequencer state encoding
//   pix_sb_t       : per-pixel sideband carried alongside the ROM read
package sprite_pkg;

    localparam int COLOR_W = 12;
    localparam int CNT_W   = 10;
    localparam int IDX_W   = 4;

    localparam logic [COLOR_W-1:0] TRANSP_DEFAULT = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } anim_state_e;

    typedef struct packed {
        logic               on;
        logic               bright;
        logic [COLOR_W-1:0] bg;
    } pix_sb_t;

endpackage

// File: rtl/sprite_anim_seq.sv
// Frame sequencer: chooses which stored animation frame is displayed.
// Ports:
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   frame_tick_i   : one-cycle pulse per video frame; the only event that advances frames
//   anim_start_i   : restart at frame 0 (latches anim_loop_i)
//   anim_loop_i    : 1 = wrap after last frame, 0 = stop in DONE
//   anim_stop_i    : return to IDLE and freeze the current frame (wins over start)
//   frame_idx_o    : frame currently displayed
//   busy_o         : high while in PLAY
//   state_o        : current sequencer state, for observation
// All control inputs are single-cycle strobes sampled on the rising clock edge;
// there is no valid/ready handshake on this block.
module sprite_anim_seq
    import sprite_pkg::*;
#(
    parameter int FRAMES     = 4,
    parameter int HOLD_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick_i,
    input  logic             anim_start_i,
    input  logic             anim_loop_i,
    input  logic             anim_stop_i,
    output logic [IDX_W-1:0] frame_idx_o,
    output logic             busy_o,
    output anim_state_e      state_o
);

    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAMES - 1);

    anim_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic              loop_q,  loop_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            loop_q  <= loop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        loop_d  = loop_q;

        if (anim_stop_i) begin
            // Stop has priority over a simultaneous start; frame index is frozen.
            state_d = IDLE;
        end else if (anim_start_i) begin
            state_d = PLAY;
            idx_d   = '0;
            hold_d  = '0;
            loop_d  = anim_loop_i;
        end else if (state_q == PLAY && frame_tick_i) begin
            if (hold_q == HOLD_LAST) begin
                hold_d = '0;
                if (idx_q < IDX_LAST) begin
                    idx_d = idx_q + 1'b1;
                end else if (loop_q) begin
                    idx_d = '0;
                end else begin
                    // One-shot: park on the last frame.
                    state_d = DONE;
                end
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    assign frame_idx_o = idx_q;
    assign busy_o      = (state_q == PLAY);
    assign state_o     = state_q;

endmodule

// File: rtl/sprite_animator.sv
// Animated sprite layer: overlays one WxH sprite, fetched from an external
// synchronous multi-frame ROM, onto the incoming background at a movable position.
// Ports:
//   clk, rst_n             : pixel clock, asynchronous active-low reset
//   bright, hCount, vCount : VGA display-area flag and current pixel coordinates
//   background             : colour of the layer underneath, aligned with hCount/vCount
//   frame_tick             : one-cycle pulse per video frame
//   pos_load, pos_x, pos_y : write a new sprite position into the shadow register
//   anim_start/loop/stop   : animation control strobes
//   rom_addr / rom_data    : ROM read port; data returns ROM_LAT cycles after rom_addr
//   rgb, sprite_hit        : output pixel and opaque-sprite flag, ROM_LAT+1 cycles after input
//   frame_idx, busy        : frame being shown, sequencer playing
//   seq_state              : sequencer state, for observation
module sprite_animator
    import sprite_pkg::*;
#(
    parameter int                 W          = 45,
    parameter int                 H          = 45,
    parameter int                 FRAMES     = 4,
    parameter int                 HOLD_TICKS = 8,
    parameter int                 ROM_LAT    = 1,
    parameter logic [COLOR_W-1:0] TRANSP     = TRANSP_DEFAULT,
    parameter int                 X0         = 228,
    parameter int                 Y0         = 160,
    localparam int                ADDR_W     = (FRAMES * W * H > 1) ? $clog2(FRAMES * W * H) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bright,
    input  logic [CNT_W-1:0]   hCount,
    input  logic [CNT_W-1:0]   vCount,
    input  logic [COLOR_W-1:0] background,
    input  logic               frame_tick,
    input  logic               pos_load,
    input  logic [CNT_W-1:0]   pos_x,
    input  logic [CNT_W-1:0]   pos_y,
    input  logic               anim_start,
    input  logic               anim_loop,
    input  logic               anim_stop,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [COLOR_W-1:0] rgb,
    output logic               sprite_hit,
    output logic [IDX_W-1:0]   frame_idx,
    output logic               busy,
    output anim_state_e        seq_state
);

    localparam int FRAME_SZ = W * H;

    // ---------------- position registers ----------------
    // pos_load only updates the shadow copy; the live copy follows on frame_tick
    // so the sprite never moves part-way through a frame.
    logic [CNT_W-1:0] shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
    logic [CNT_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;

    always_comb begin
        shadow_x_d = pos_load ? pos_x : shadow_x_q;
        shadow_y_d = pos_load ? pos_y : shadow_y_q;
        xpos_d     = frame_tick ? shadow_x_d : xpos_q;
        ypos_d     = frame_tick ? shadow_y_d : ypos_q;
    end

    // ---------------- frame sequencer ----------------
    sprite_anim_seq #(
        .FRAMES     (FRAMES),
        .HOLD_TICKS (HOLD_TICKS)
    ) u_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick_i (frame_tick),
        .anim_start_i (anim_start),
        .anim_loop_i  (anim_loop),
        .anim_stop_i  (anim_stop),
        .frame_idx_o  (frame_idx),
        .busy_o       (busy),
        .state_o      (seq_state)
    );

    // ---------------- cycle 0: hit test and address ----------------
    // One extra bit so a sprite crossing column/row 1023 does not wrap to 0.
    logic [CNT_W:0]      h_ext, v_ext, x_ext, y_ext, col, row;
    logic                on_x, on_y, on_c;
    logic [ADDR_W-1:0]   base, offs, rom_addr_d, rom_addr_q;
    pix_sb_t             sb_d;

    assign h_ext = {1'b0, hCount};
    assign v_ext = {1'b0, vCount};
    assign x_ext = {1'b0, xpos_q};
    assign y_ext = {1'b0, ypos_q};
    assign col   = h_ext - x_ext;
    assign row   = v_ext - y_ext;
    assign on_x  = (h_ext >= x_ext) && (h_ext < x_ext + (CNT_W + 1)'(W));
    assign on_y  = (v_ext >= y_ext) && (v_ext < y_ext + (CNT_W + 1)'(H));
    assign on_c  = on_x && on_y;

    // Off-sprite pixels still point at the frame base so the ROM sees a legal address.
    assign base       = ADDR_W'(int'(frame_idx) * FRAME_SZ);
    assign offs       = on_c ? ADDR_W'(int'(row) * W + int'(col)) : '0;
    assign rom_addr_d = base + offs;

    assign sb_d.on     = on_c;
    assign sb_d.bright = bright;
    assign sb_d.bg     = background;

    // ---------------- sideband delay and output stage ----------------
    // sb_q[0] is loaded with rom_addr; sb_q[ROM_LAT] lines up with rom_data.
    pix_sb_t            sb_q [0:ROM_LAT];
    pix_sb_t            sb_last;
    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic               hit_q, hit_d;

    assign sb_last = sb_q[ROM_LAT];

    always_comb begin
        rgb_d = '0;
        hit_d = 1'b0;
        if (!sb_last.bright) begin
            rgb_d = '0;
        end else if (sb_last.on && rom_data != TRANSP) begin
            rgb_d = rom_data;
            hit_d = 1'b1;
        end else begin
            rgb_d = sb_last.bg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_x_q <= CNT_W'(X0);
            shadow_y_q <= CNT_W'(Y0);
            xpos_q     <= CNT_W'(X0);
            ypos_q     <= CNT_W'(Y0);
            rom_addr_q <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                sb_q[i] <= '0;
            end
            rgb_q      <= '0;
            hit_q      <= 1'b0;
        end else begin
            shadow_x_q <= shadow_x_d;
            shadow_y_q <= shadow_y_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            rom_addr_q <= rom_addr_d;
            sb_q[0]    <= sb_d;
            for (int i = 1; i <= ROM_LAT; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
            rgb_q      <= rgb_d;
            hit_q      <= hit_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign rgb        = rgb_q;
    assign sprite_hit = hit_q;

endmodule

// File: tb/tb_sprite_animator.sv
module tb_sprite_animator;
    import sprite_pkg::*;

    // ---------------- clock / reset / DUT signals ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bright = 1'b0;
    logic [9:0]  hCount = '0;
    logic [9:0]  vCount = '0;
    logic [11:0] background = '0;
    logic        frame_tick = 1'b0;
    logic        pos_load = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        anim_start = 1'b0;
    logic        anim_loop = 1'b0;
    logic        anim_stop = 1'b0;

    logic [12:0] addr1, addr3;
    logic [11:0] rom1 = '0, rom3 = '0, r3a = '0, r3b = '0;
    logic [11:0] rgb1, rgb3;
    logic        hit1, hit3, busy1, busy3;
    logic [3:0]  idx1, idx3;
    anim_state_e st1, st3;

    always #5 clk = ~clk;

    sprite_animator #(.HOLD_TICKS(2), .ROM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bright(bright), .hCount(hCount), .vCount(vCount),
        .background(background), .frame_tick(frame_tick), .pos_load(pos_load),
        .pos_x(pos_x), .pos_y(pos_y), .anim_start(anim_start), .anim_loop(anim_loop),
        .anim_stop(anim_stop), .rom_addr(addr1), .rom_data(rom1), .rgb(rgb1),
        .sprite_hit(hit1), .frame_idx(idx1), .busy(busy1), .seq_state(st1)
    );

    sprite_animator #(.HOLD_TICKS(2), .ROM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bright(bright), .hCount(hCount), .vCount(vCount),
        .background(background), .frame_tick(frame_tick), .pos_load(pos_load),
        .pos_x(pos_x), .pos_y(pos_y), .anim_start(anim_start), .anim_loop(anim_loop),
        .anim_stop(anim_stop), .rom_addr(addr3), .rom_data(rom3), .rgb(rgb3),
        .sprite_hit(hit3), .frame_idx(idx3), .busy(busy3), .seq_state(st3)
    );

    // ---------------- ROM models ----------------
    // Frame 0: all 12'h123 except pixel (row 1, col 2) = transparent key.
    // Frame f>0: {f, 8'h55}.
    function automatic logic [11:0] rom_word(input logic [12:0] a);
        int f, p;
        logic [31:0] fv;
        f  = int'(a) / 2025;
        p  = int'(a) % 2025;
        fv = f;
        if (f == 0) return (p == 47) ? 12'hFFF : 12'h123;
        return {fv[3:0], 8'h55};
    endfunction

    always @(posedge clk) begin
        rom1 <= rom_word(addr1);
        r3a  <= rom_word(addr3);
        r3b  <= r3a;
        rom3 <= r3b;
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        b;
        logic [11:0] bg;
        logic [11:0] exp_rgb;
        logic        exp_hit;
        logic [12:0] exp_addr;
    } pix_vec_t;

    pix_vec_t vec[32];
    int       nvec = 0;

    task automatic add_vec(input logic [9:0] h, input logic [9:0] v, input logic b,
                           input logic [11:0] bg, input logic [11:0] er, input logic eh,
                           input logic [12:0] ea);
        vec[nvec] = '{h, v, b, bg, er, eh, ea};
        nvec++;
    endtask

    // Streams one vector per cycle. Inputs driven before sampling edge k appear on
    // rom_addr after edge k and on rgb after edge k+L (L = ROM_LAT+1).
    task automatic run_stream(input string tag);
        for (int i = 0; i < nvec + 5; i++) begin
            @(negedge clk);
            if (i >= 1 && i - 1 < nvec) begin
                check($sformatf("%s addr1[%0d]", tag, i - 1), 32'(addr1), 32'(vec[i-1].exp_addr));
                check($sformatf("%s addr3[%0d]", tag, i - 1), 32'(addr3), 32'(vec[i-1].exp_addr));
            end
            if (i >= 3 && i - 3 < nvec) begin
                check($sformatf("%s rgb1[%0d]", tag, i - 3), 32'(rgb1), 32'(vec[i-3].exp_rgb));
                check($sformatf("%s hit1[%0d]", tag, i - 3), 32'(hit1), 32'(vec[i-3].exp_hit));
            end
            if (i >= 5 && i - 5 < nvec) begin
                check($sformatf("%s rgb3[%0d]", tag, i - 5), 32'(rgb3), 32'(vec[i-5].exp_rgb));
                check($sformatf("%s hit3[%0d]", tag, i - 5), 32'(hit3), 32'(vec[i-5].exp_hit));
            end
            if (i < nvec) begin
                hCount = vec[i].h; vCount = vec[i].v; bright = vec[i].b; background = vec[i].bg;
            end else begin
                hCount = '0; vCount = '0; bright = 1'b0; background = '0;
            end
        end
        nvec = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    task automatic do_start(input logic lp);
        @(negedge clk); anim_start = 1'b1; anim_loop = lp;
        @(negedge clk); anim_start = 1'b0; anim_loop = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk); anim_stop = 1'b1;
        @(negedge clk); anim_stop = 1'b0;
    endtask

    task automatic check_seq(input string name, input logic [3:0] ei, input logic eb,
                             input anim_state_e es);
        check({name, " idx1"},  32'(idx1),  32'(ei));
        check({name, " idx3"},  32'(idx3),  32'(ei));
        check({name, " busy1"}, 32'(busy1), 32'(eb));
        check({name, " st1"},   32'(st1),   32'(es));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int exp_seq[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

        // Test 1: reset state, then first-frame pixels and latency for both ROM latencies.
        @(negedge clk);
        check("rst rgb1", 32'(rgb1), 32'h0);
        check("rst rgb3", 32'(rgb3), 32'h0);
        check("rst hit1", 32'(hit1), 32'h0);
        check("rst addr1", 32'(addr1), 32'h0);
        check_seq("rst", 4'd0, 1'b0, IDLE);
        @(negedge clk); rst_n = 1'b1;

        add_vec(10'd228, 10'd160, 1'b1, 12'h0F0, 12'h123, 1'b1, 13'd0);
        add_vec(10'd227, 10'd160, 1'b1, 12'h0F0, 12'h0F0, 1'b0, 13'd0);
        add_vec(10'd273, 10'd160, 1'b1, 12'h0F0, 12'h0F0, 1'b0, 13'd0);
        add_vec(10'd272, 10'd160, 1'b1, 12'h0F0, 12'h123, 1'b1, 13'd44);
        add_vec(10'd230, 10'd161, 1'b1, 12'h0A5, 12'h0A5, 1'b0, 13'd47);  // transparent key
        add_vec(10'd230, 10'd161, 1'b0, 12'h0A5, 12'h000, 1'b0, 13'd47);  // blanking
        add_vec(10'd228, 10'd159, 1'b1, 12'h0F0, 12'h0F0, 1'b0, 13'd0);
        add_vec(10'd228, 10'd204, 1'b1, 12'h0F0, 12'h123, 1'b1, 13'd1980);
        add_vec(10'd228, 10'd205, 1'b1, 12'h0F0, 12'h0F0, 1'b0, 13'd0);
        add_vec(10'd250, 10'd180, 1'b0, 12'h0F0, 12'h000, 1'b0, 13'd922);
        add_vec(10'd231, 10'd161, 1'b1, 12'h0F0, 12'h123, 1'b1, 13'd48);
        add_vec(10'd0,   10'd0,   1'b1, 12'h321, 12'h321, 1'b0, 13'd0);
        run_stream("t1");

        // Test 3: looped animation, HOLD_TICKS=2.
        do_start(1'b1);
        check_seq("t3 start", 4'd0, 1'b1, PLAY);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t3 idx1 tick%0d", k + 1), 32'(idx1), 32'(exp_seq[k]));
            check($sformatf("t3 idx3 tick%0d", k + 1), 32'(idx3), 32'(exp_seq[k]));
            check($sformatf("t3 addr1 tick%0d", k + 1), 32'(addr1), 32'(exp_seq[k] * 2025));
            pulse_tick();
        end
        @(negedge clk);
        check_seq("t3 wrap", 4'd0, 1'b1, PLAY);
        check("t3 wrap addr1", 32'(addr1), 32'd0);
        do_stop();
        check_seq("t3 stop", 4'd0, 1'b0, IDLE);

        // Test 4: one-shot, then start+stop collision.
        do_start(1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) check_seq("t4 pre-last", 4'd3, 1'b1, PLAY);
            pulse_tick();
        end
        check_seq("t4 done", 4'd3, 1'b0, DONE);
        pulse_tick();
        check_seq("t4 done hold", 4'd3, 1'b0, DONE);
        do_start(1'b0);
        pulse_tick();
        pulse_tick();
        check_seq("t4 replay", 4'd1, 1'b1, PLAY);
        @(negedge clk); anim_start = 1'b1; anim_stop = 1'b1;
        @(negedge clk); anim_start = 1'b0; anim_stop = 1'b0;
        check_seq("t4 start+stop", 4'd1, 1'b0, IDLE);
        pulse_tick();
        check_seq("t4 frozen", 4'd1, 1'b0, IDLE);

        // Test 5: shadow position, applied on frame_tick, no wrap at column 1023.
        @(negedge clk); pos_x = 10'd1000; pos_y = 10'd470; pos_load = 1'b1;
        @(negedge clk); pos_load = 1'b0;
        add_vec(10'd228,  10'd160, 1'b1, 12'h0F0, 12'h155, 1'b1, 13'd2025);
        add_vec(10'd1000, 10'd470, 1'b1, 12'h0F0, 12'h0F0, 1'b0, 13'd2025);
        run_stream("t5 pre");
        pulse_tick();
        add_vec(10'd1000, 10'd470, 1'b1, 12'h0F0, 12'h155, 1'b1, 13'd2025);
        add_vec(10'd1023, 10'd470, 1'b1, 12'h0F0, 12'h155, 1'b1, 13'd2048);
        add_vec(10'd228,  10'd160, 1'b1, 12'h0F0, 12'h0F0, 1'b0, 13'd2025);
        add_vec(10'd0,    10'd471, 1'b1, 12'h0F0, 12'h0F0, 1'b0, 13'd2025);
        add_vec(10'd20,   10'd471, 1'b1, 12'h0F0, 12'h0F0, 1'b0, 13'd2025);
        add_vec(10'd1022, 10'd471, 1'b1, 12'h0F0, 12'h155, 1'b1, 13'd2092);
        run_stream("t5 post");
        // pos_load and frame_tick together: new position live immediately.
        @(negedge clk); pos_x = 10'd300; pos_y = 10'd100; pos_load = 1'b1; frame_tick = 1'b1;
        @(negedge clk); pos_load = 1'b0; frame_tick = 1'b0;
        add_vec(10'd300, 10'd100, 1'b1, 12'h0F0, 12'h155, 1'b1, 13'd2025);
        add_vec(10'd299, 10'd100, 1'b1, 12'h0F0, 12'h0F0, 1'b0, 13'd2025);
        run_stream("t5 same");

        // Test 6: reset mid-animation and mid-line.
        do_start(1'b1);
        for (int k = 0; k < 4; k++) pulse_tick();
        check_seq("t6 frame2", 4'd2, 1'b1, PLAY);
        hCount = 10'd300; vCount = 10'd100; bright = 1'b1; background = 12'h0F0;
        repeat (6) @(negedge clk);
        check("t6 rgb1 pre", 32'(rgb1), 32'h255);
        check("t6 rgb3 pre", 32'(rgb3), 32'h255);
        rst_n = 1'b0;
        #1;
        check_seq("t6 in reset", 4'd0, 1'b0, IDLE);
        check("t6 rgb1 rst", 32'(rgb1), 32'h0);
        check("t6 rgb3 rst", 32'(rgb3), 32'h0);
        check("t6 hit1 rst", 32'(hit1), 32'h0);
        check("t6 addr1 rst", 32'(addr1), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6 rgb1 post", 32'(rgb1), 32'h0);
        check("t6 rgb3 post", 32'(rgb3), 32'h0);
        add_vec(10'd228, 10'd160, 1'b1, 12'h0F0, 12'h123, 1'b1, 13'd0);
        add_vec(10'd300, 10'd100, 1'b1, 12'h0F0, 12'h0F0, 1'b0, 13'd0);
        add_vec(10'd229, 10'd160, 1'b1, 12'h0F0, 12'h123, 1'b1, 13'd1);
        run_stream("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
